key_conditioner: RTL and testbench

- Upstream input stage of the mole-game datapath: conditions the four raw, active-low DE2 push-buttons (KEY) before the game logic consumes them.
- Per key: 2-flop synchronizer, counter-based debounce, registered press/release strobes, and a one-shot long-press strobe.
- The game FSM uses key_press strobes for hits, and KEY[0]'s strobe for start/advance. It never samples raw KEY.

---
 rtl/topeira_pkg.sv | 19 +
 rtl/key_conditioner_if.sv | 30 +++
 rtl/key_debounce_1ch.sv | 107 ++++++++++
 rtl/key_conditioner.sv | 32 +++
 tb/tb_key_conditioner.sv | 123 ++++++++++++
 5 files changed

// File: rtl/topeira_pkg.sv
// Shared definitions for the mole-game datapath: key FSM states and timing defaults.
package topeira_pkg;

    // Per-key conditioner state; KS_SPARE is never entered on purpose.
    typedef enum logic [1:0] {
        KS_RELEASED  = 2'd0,
        KS_PRESSED   = 2'd1,
        KS_LONG_HELD = 2'd2,
        KS_SPARE     = 2'd3
    } key_state_t;

    // Default timing at 50 MHz.
    localparam int unsigned DEBOUNCE_20MS = 1_000_000;
    localparam int unsigned LONG_1S       = 50_000_000;

    // Game key assignments.
    localparam int unsigned KEY_START = 0;

endpackage

// File: rtl/key_conditioner_if.sv
// Raw key inputs and conditioned key outputs between board pins and game logic.
interface key_conditioner_if #(
    parameter int unsigned N_KEYS = 4
);

    logic [N_KEYS-1:0] KEY;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;

    // Board / stimulus side: drives raw keys, observes conditioned outputs.
    modport master (
        output KEY,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long
    );

    // Conditioner side.
    modport slave (
        input  KEY,
        output key_level,
        output key_press,
        output key_release,
        output key_long
    );

endinterface

// File: rtl/key_debounce_1ch.sv
// One key: 2-flop synchronizer, debounce counter, press/release/long-press strobes.
module key_debounce_1ch
    import topeira_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int unsigned LONG_CYCLES     = LONG_1S,
    parameter int unsigned CNT_W           = 26
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    // hold_cnt reaches LONG_CYCLES-1 on the edge it is incremented from this value.
    localparam logic [CNT_W-1:0] HOLD_PRE = CNT_W'(LONG_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    logic             p;
    logic             rel_hit;
    key_state_t       state;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] hold_cnt;

    assign p       = ~s2;
    assign rel_hit = ~p && (db_cnt == DB_LAST);

    // Synchronize the asynchronous active-low button; idles released.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

    // Debounce FSM with registered one-cycle strobes; release wins over long-press.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= KS_RELEASED;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            case (state)
                KS_RELEASED: begin
                    if (p) begin
                        if (db_cnt == DB_LAST) begin
                            state     <= KS_PRESSED;
                            key_level <= 1'b1;
                            key_press <= 1'b1;
                            db_cnt    <= '0;
                            hold_cnt  <= '0;
                        end else begin
                            db_cnt <= db_cnt + CNT_ONE;
                        end
                    end else begin
                        db_cnt <= '0;
                    end
                end
                KS_PRESSED, KS_LONG_HELD: begin
                    if (rel_hit) begin
                        state       <= KS_RELEASED;
                        key_level   <= 1'b0;
                        key_release <= 1'b1;
                        db_cnt      <= '0;
                        hold_cnt    <= '0;
                    end else begin
                        if (!p) begin
                            db_cnt <= db_cnt + CNT_ONE;
                        end else begin
                            db_cnt <= '0;
                        end
                        if (state == KS_PRESSED) begin
                            hold_cnt <= hold_cnt + CNT_ONE;
                            if (hold_cnt == HOLD_PRE) begin
                                state    <= KS_LONG_HELD;
                                key_long <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state     <= KS_RELEASED;
                    key_level <= 1'b0;
                    db_cnt    <= '0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Conditions the DE2 push-buttons: one independent debounce channel per key.
module key_conditioner
    import topeira_pkg::*;
#(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int unsigned LONG_CYCLES     = LONG_1S,
    parameter int unsigned CNT_W           = 26
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    key_conditioner_if.slave  kif
);

    // One channel per key; channels share nothing but clock and reset.
    for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_key
        key_debounce_1ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .CLOCK_50    (CLOCK_50),
            .reset       (reset),
            .key_n       (kif.KEY[i]),
            .key_level   (kif.key_level[i]),
            .key_press   (kif.key_press[i]),
            .key_release (kif.key_release[i]),
            .key_long    (kif.key_long[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/long-press thresholds.
module tb_key_conditioner;

    localparam int unsigned NK = 4;
    localparam int unsigned NT = 31;

    typedef struct {
        logic [3:0] key;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] lng;
    } vec_t;

    logic CLOCK_50;
    logic reset;
    int   n_pass;
    int   n_total;
    vec_t tbl [NT];

    key_conditioner_if #(.N_KEYS(NK)) kif ();

    key_conditioner #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (12),
        .CNT_W           (5)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .kif      (kif)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string nm, input logic [3:0] el, input logic [3:0] ep,
                         input logic [3:0] er, input logic [3:0] eg);
        logic [15:0] act;
        logic [15:0] exp;
        act = {kif.key_level, kif.key_press, kif.key_release, kif.key_long};
        exp = {el, ep, er, eg};
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got lvl/prs/rel/lng=%h required %h", nm, $time, act, exp);
    endtask

    // Apply KEY now, advance one rising edge, sample 1 time unit later.
    task automatic cyc(input logic [3:0] k, input logic [3:0] el, input logic [3:0] ep,
                       input logic [3:0] er, input logic [3:0] eg, input string nm);
        kif.KEY = k;
        @(posedge CLOCK_50);
        #1;
        check(nm, el, ep, er, eg);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        kif.KEY = 4'hF;
        #1;
        check("reset_state", 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        check("reset_hold", 4'h0, 4'h0, 4'h0, 4'h0);

        // Table: clean press/release on KEY[0], then all four keys at once.
        for (int k = 0; k < int'(NT); k++)
            tbl[k] = '{key: 4'hF, lvl: 4'h0, prs: 4'h0, rel: 4'h0, lng: 4'h0};
        for (int k = 0; k <= 7; k++)  tbl[k].key = 4'hE;
        for (int k = 5; k <= 12; k++) tbl[k].lvl = 4'h1;
        tbl[5].prs  = 4'h1;
        tbl[13].rel = 4'h1;
        for (int k = 15; k <= 23; k++) tbl[k].key = 4'h0;
        for (int k = 20; k <= 28; k++) tbl[k].lvl = 4'hF;
        tbl[20].prs = 4'hF;
        tbl[29].rel = 4'hF;
        for (int k = 0; k < int'(NT); k++)
            cyc(tbl[k].key, tbl[k].lvl, tbl[k].prs, tbl[k].rel, tbl[k].lng, $sformatf("tbl[%0d]", k));

        // Bounce on KEY[1]: 3 low, 1 high, 3 low, then high; never accepted.
        for (int i = 0; i < 3; i++) cyc(4'hD, 4'h0, 4'h0, 4'h0, 4'h0, "bounce_a");
        cyc(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "bounce_gap");
        for (int i = 0; i < 3; i++) cyc(4'hD, 4'h0, 4'h0, 4'h0, 4'h0, "bounce_b");
        for (int i = 0; i < 5; i++) cyc(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "bounce_idle");
        // Then a steady press on KEY[1].
        for (int i = 0; i < 10; i++)
            cyc(4'hD, (i >= 5) ? 4'h2 : 4'h0, (i == 5) ? 4'h2 : 4'h0, 4'h0, 4'h0, "bounce_press");
        for (int i = 0; i < 8; i++)
            cyc(4'hF, (i < 5) ? 4'h2 : 4'h0, 4'h0, (i == 5) ? 4'h2 : 4'h0, 4'h0, "bounce_release");

        // Long press on KEY[2]: one long strobe 11 edges after the press, no repeat.
        for (int i = 0; i < 30; i++)
            cyc(4'hB, (i >= 5) ? 4'h4 : 4'h0, (i == 5) ? 4'h4 : 4'h0, 4'h0,
                (i == 16) ? 4'h4 : 4'h0, "long_hold");
        for (int i = 0; i < 8; i++)
            cyc(4'hF, (i < 5) ? 4'h4 : 4'h0, 4'h0, (i == 5) ? 4'h4 : 4'h0, 4'h0, "long_release");

        // Collision on KEY[0]: release threshold lands on the long-press edge.
        for (int i = 0; i < 24; i++)
            cyc((i < 11) ? 4'hE : 4'hF, (i >= 5 && i < 16) ? 4'h1 : 4'h0,
                (i == 5) ? 4'h1 : 4'h0, (i == 16) ? 4'h1 : 4'h0, 4'h0, "collision");

        // Reset mid-press on KEY[3].
        for (int i = 0; i < 8; i++)
            cyc(4'h7, (i >= 5) ? 4'h8 : 4'h0, (i == 5) ? 4'h8 : 4'h0, 4'h0, 4'h0, "rst_press");
        reset = 1'b1;
        #1;
        check("rst_async", 4'h0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 2; i++) cyc(4'h7, 4'h0, 4'h0, 4'h0, 4'h0, "rst_held");
        reset = 1'b0;
        for (int i = 0; i < 8; i++)
            cyc(4'h7, (i >= 5) ? 4'h8 : 4'h0, (i == 5) ? 4'h8 : 4'h0, 4'h0, 4'h0, "rst_repress");
        for (int i = 0; i < 8; i++)
            cyc(4'hF, (i < 5) ? 4'h8 : 4'h0, 4'h0, (i == 5) ? 4'h8 : 4'h0, 4'h0, "rst_release");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
